// File: rtl/key_mode_pkg.sv
// Shared types and constants for the key-driven blink-mode controller.
package key_mode_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_DEB,
    HELD,
    REL_DEB
  } state_t;

  localparam int unsigned MODE_W = 2;

  // Blinker half-period per mode; board builds substitute Hz-scale counts.
  localparam logic [31:0] PERIOD_TBL [4] = '{32'd4, 32'd8, 32'd16, 32'd32};

  function automatic logic [31:0] period_of(input logic [MODE_W-1:0] m);
    return PERIOD_TBL[m];
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous bit; resets to 1 (key released).
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1;

  // Shift the raw input through two flops
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b1;
      q  <= 1'b1;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/key_mode_ctrl.sv
// Push-button front end: debounces key_n, classifies short/long presses,
// steps the blink mode on short presses and toggles the blinker on long ones.
module key_mode_ctrl
  import key_mode_pkg::*;
#(
  parameter logic [31:0] DEB_CYC  = 32'd20,
  parameter logic [31:0] LONG_CYC = 32'd50_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_n,
  output logic [31:0]       period,
  output logic              blink_en,
  output logic [MODE_W-1:0] mode,
  output logic              short_pulse,
  output logic              long_pulse
);

  state_t      state, state_nxt;
  logic        key_s;
  logic [31:0] deb_cnt;
  logic [31:0] hold_cnt;
  logic        long_done;

  logic        deb_end;
  logic        deb_clr, deb_inc;
  logic        press_acc;
  logic        hold_inc;
  logic        long_fire, short_fire;

  sync2 u_sync2 (
    .clk (clk),
    .rst (rst),
    .d   (key_n),
    .q   (key_s)
  );

  assign deb_end = (deb_cnt == DEB_CYC - 32'd1);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode from the synchronized key level
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (!key_s) state_nxt = PRESS_DEB;
      PRESS_DEB: begin
        if (key_s)        state_nxt = IDLE;
        else if (deb_end) state_nxt = HELD;
      end
      HELD:      if (key_s) state_nxt = REL_DEB;
      REL_DEB:   begin
        if (!key_s)       state_nxt = HELD;
        else if (deb_end) state_nxt = IDLE;
      end
      default:   state_nxt = IDLE;
    endcase
  end

  // Counter controls and pulse decisions; hold_cnt only advances while the
  // key is seen low in HELD, so a rejected release bounce freezes it.
  always_comb begin
    deb_clr    = ((state == IDLE) && !key_s) || ((state == HELD) && key_s);
    deb_inc    = ((state == PRESS_DEB) && !key_s) || ((state == REL_DEB) && key_s);
    press_acc  = (state == PRESS_DEB) && !key_s && deb_end;
    hold_inc   = (state == HELD) && !key_s && (hold_cnt != LONG_CYC);
    long_fire  = (state == HELD) && !key_s && (hold_cnt == LONG_CYC - 32'd1) && !long_done;
    short_fire = (state == REL_DEB) && key_s && deb_end && !long_done;
  end

  // Counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      deb_cnt     <= '0;
      hold_cnt    <= '0;
      long_done   <= 1'b0;
      short_pulse <= 1'b0;
      long_pulse  <= 1'b0;
      blink_en    <= 1'b1;
      mode        <= '0;
      period      <= period_of('0);
    end else begin
      if (deb_clr)      deb_cnt <= '0;
      else if (deb_inc) deb_cnt <= deb_cnt + 32'd1;

      if (press_acc)     hold_cnt <= '0;
      else if (hold_inc) hold_cnt <= hold_cnt + 32'd1;

      if (press_acc)      long_done <= 1'b0;
      else if (long_fire) long_done <= 1'b1;

      short_pulse <= short_fire;
      long_pulse  <= long_fire;

      if (long_fire) blink_en <= ~blink_en;

      if (short_fire) begin
        mode   <= mode + 2'd1;
        period <= period_of(mode + 2'd1);
      end
    end
  end

endmodule

// File: tb/tb_key_mode_ctrl.sv
// Self-checking bench for key_mode_ctrl with a run-length reference model.
module tb_key_mode_ctrl;

  localparam int DEB  = 4;
  localparam int LONG = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        key_n = 1'b1;
  logic [31:0] period;
  logic        blink_en;
  logic [1:0]  mode;
  logic        short_pulse;
  logic        long_pulse;

  key_mode_ctrl #(
    .DEB_CYC  (32'd4),
    .LONG_CYC (32'd16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .key_n       (key_n),
    .period      (period),
    .blink_en    (blink_en),
    .mode        (mode),
    .short_pulse (short_pulse),
    .long_pulse  (long_pulse)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: 2-sample input delay, debounced level with a run
  // counter of disagreeing samples, and a count of pressed samples.
  logic m_d1, m_d2;
  logic m_pressed;
  int   m_run, m_hold, m_mode;
  logic m_ldone, m_blink, m_short, m_long;

  int cyc = 0;
  int n_short = 0, n_long = 0;
  int last_short = -1, last_long = -1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  task automatic model_step(input logic k, input logic r);
    logic samp;
    if (r) begin
      m_d1 = 1'b1; m_d2 = 1'b1; m_pressed = 1'b0; m_run = 0; m_hold = 0;
      m_ldone = 1'b0; m_mode = 0; m_blink = 1'b1; m_short = 1'b0; m_long = 1'b0;
    end else begin
      samp = m_d2;
      m_d2 = m_d1;
      m_d1 = k;
      m_short = 1'b0;
      m_long  = 1'b0;
      if ((!samp) == m_pressed) begin
        if (m_pressed && m_run == 0 && m_hold < LONG) begin
          m_hold++;
          if (m_hold == LONG && !m_ldone) begin
            m_long = 1'b1; m_blink = ~m_blink; m_ldone = 1'b1;
          end
        end
        m_run = 0;
      end else begin
        m_run++;
        if (m_run == DEB + 1) begin
          m_pressed = ~m_pressed;
          m_run = 0;
          if (m_pressed) begin
            m_hold = 0; m_ldone = 1'b0;
          end else if (!m_ldone) begin
            m_short = 1'b1; m_mode = (m_mode + 1) % 4;
          end
        end
      end
    end
  endtask

  // One clock with given inputs, then compare every output to the model
  task automatic tick(input logic k, input logic r);
    cyc++;
    key_n = k;
    rst   = r;
    @(posedge clk);
    model_step(k, r);
    #1;
    check_eq("mode",        32'(mode),        32'(m_mode));
    check_eq("period",      period,           32'(4 << m_mode));
    check_eq("blink_en",    32'(blink_en),    32'(m_blink));
    check_eq("short_pulse", 32'(short_pulse), 32'(m_short));
    check_eq("long_pulse",  32'(long_pulse),  32'(m_long));
    if (short_pulse && long_pulse) check_eq("pulse_excl", 32'd1, 32'd0);
    if (short_pulse) begin n_short++; last_short = cyc; end
    if (long_pulse)  begin n_long++;  last_long  = cyc; end
  endtask

  task automatic hold_key(input logic k, input int n);
    for (int i = 0; i < n; i++) tick(k, 1'b0);
  endtask

  int rel, prs, s0, l0, m0;

  initial begin
    // Reset then idle
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1);
    hold_key(1'b1, 10);
    check_eq("reset_mode",   32'(mode), 32'd0);
    check_eq("reset_period", period,    32'd4);
    check_eq("reset_blink",  32'(blink_en), 32'd1);
    check_eq("reset_pulses", 32'(n_short + n_long), 32'd0);

    // Four clean short presses: mode steps and wraps
    for (int p = 0; p < 4; p++) begin
      hold_key(1'b0, 10);
      rel = cyc + 1;
      last_short = -1;
      hold_key(1'b1, 12);
      check_eq("short_latency", 32'(last_short - rel), 32'(2 + DEB));
      check_eq("short_mode", 32'(mode), 32'((p + 1) % 4));
    end
    check_eq("wrap_period", period, 32'd4);

    // Bouncing key: no pulse, mode unchanged
    s0 = n_short; l0 = n_long; m0 = mode;
    for (int b = 0; b < 5; b++) begin
      hold_key(1'b0, 3);
      hold_key(1'b1, 3);
    end
    hold_key(1'b1, 8);
    check_eq("bounce_pulses", 32'(n_short + n_long - s0 - l0), 32'd0);
    check_eq("bounce_mode",   32'(mode), 32'(m0));

    // Two long presses: blink toggles off then on, no short on release
    for (int p = 0; p < 2; p++) begin
      s0 = n_short;
      prs = cyc + 1;
      last_long = -1;
      hold_key(1'b0, 30);
      check_eq("long_latency", 32'(last_long - prs), 32'(2 + DEB + LONG));
      check_eq("long_blink",   32'(blink_en), (p == 0) ? 32'd0 : 32'd1);
      hold_key(1'b1, 12);
      check_eq("long_no_short", 32'(n_short - s0), 32'd0);
    end

    // Release glitch mid-hold is absorbed: exactly one long press
    s0 = n_short; l0 = n_long;
    hold_key(1'b0, 12);
    hold_key(1'b1, 2);
    hold_key(1'b0, 16);
    hold_key(1'b1, 12);
    check_eq("glitch_long",  32'(n_long - l0),  32'd1);
    check_eq("glitch_short", 32'(n_short - s0), 32'd0);

    // Reset during a hold aborts it; a fresh press is detected afterwards
    s0 = n_short; l0 = n_long;
    hold_key(1'b0, 8);
    check_eq("abort_pre_rst", 32'(n_short + n_long - s0 - l0), 32'd0);
    tick(1'b0, 1'b1);
    prs = cyc + 1;
    last_long = -1;
    hold_key(1'b0, 31);
    check_eq("rst_long_latency", 32'(last_long - prs), 32'(2 + DEB + LONG));
    check_eq("rst_mode", 32'(mode), 32'd0);
    hold_key(1'b1, 12);

    // Randomized run-length stimulus with occasional resets
    for (int seg = 0; seg < 300; seg++) begin
      int len;
      logic lvl;
      lvl = 1'($urandom_range(0, 1));
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(15, 40)) : int'($urandom_range(1, 8));
      if ($urandom_range(0, 40) == 0) tick(lvl, 1'b1);
      hold_key(lvl, len);
    end
    hold_key(1'b1, 12);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
